// File: rtl/decim_pkg.sv
// Shared constants and FSM encoding for the decimation controller.
package decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int NUM_DEF    = 11;
    localparam int DEN_DEF    = 16;
    localparam int SETTLE_DEF = 32;
    localparam int DEPTH_DEF  = 4;
    localparam int DATA_W     = 8;
    localparam int PHASE_W    = 5;

endpackage

// File: rtl/decim_fifo.sv
// Synchronous sample FIFO; a push into a full FIFO succeeds only alongside a pop.
module decim_fifo
    import decim_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Empty FIFO presents zero so the output is clean after reset.
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/decim_ctrl.sv
// Decimation controller: filter warm-up, fractional-rate sample capture, drain to consumer.
module decim_ctrl
    import decim_pkg::*;
#(
    parameter int NUM    = NUM_DEF,
    parameter int DEN    = DEN_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DATA_W-1:0] FILT_OUT,
    output logic              FILT_CLR,
    output logic              FILT_EN,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OVF,
    output logic [1:0]        STATE
);

    localparam int                 SW          = $clog2(SETTLE + 1);
    localparam logic [PHASE_W:0]   NUM_W       = (PHASE_W+1)'(NUM);
    localparam logic [PHASE_W:0]   DEN_W       = (PHASE_W+1)'(DEN);
    localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               ovf_q, ovf_d;
    logic [PHASE_W:0]   sum;
    logic               capture, pop, fifo_full, fifo_empty;

    assign pop       = OUT_VALID && OUT_READY;
    assign OUT_VALID = !fifo_empty;
    assign OVF       = ovf_q;
    assign STATE     = state_q;

    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        phase_d  = '0;
        FILT_CLR = 1'b0;
        FILT_EN  = 1'b0;
        capture  = 1'b0;
        sum      = {1'b0, phase_q} + NUM_W;

        case (state_q)
            ST_IDLE: begin
                FILT_CLR = 1'b1;
                if (EN) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                FILT_EN = 1'b1;
                if (!EN) begin
                    state_d = ST_IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_RUN: begin
                FILT_EN = 1'b1;
                // The last RUN cycle still captures even while leaving for DRAIN.
                if (sum >= DEN_W) begin
                    capture = 1'b1;
                    phase_d = PHASE_W'(sum - DEN_W);
                end else begin
                    phase_d = sum[PHASE_W-1:0];
                end
                if (!EN) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ovf_d = ovf_q;
        if (capture && fifo_full && !pop) ovf_d = 1'b1;
        if (state_d == ST_IDLE)           ovf_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            phase_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            phase_q  <= phase_d;
            ovf_q    <= ovf_d;
        end
    end

    decim_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (capture),
        .pop_i   (pop),
        .data_i  (FILT_OUT),
        .data_o  (OUT_DATA),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_decim_ctrl.sv
// Bench for decim_ctrl: queue-based reference model plus directed and random stimulus.
module tb_decim_ctrl;

    localparam int NUM    = 11;
    localparam int DEN    = 16;
    localparam int SETTLE = 32;
    localparam int DEPTH  = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN = 1'b0;
    logic       OUT_READY = 1'b1;
    logic [7:0] FILT_OUT = 8'd0;
    logic       FILT_CLR, FILT_EN, OUT_VALID, OVF;
    logic [7:0] OUT_DATA;
    logic [1:0] STATE;

    always #5 CLK = ~CLK;

    decim_ctrl #(
        .NUM    (NUM),
        .DEN    (DEN),
        .SETTLE (SETTLE),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .FILT_OUT  (FILT_OUT),
        .FILT_CLR  (FILT_CLR),
        .FILT_EN   (FILT_EN),
        .OUT_DATA  (OUT_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OVF       (OVF),
        .STATE     (STATE)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: 0=IDLE 1=SETTLE 2=RUN 3=DRAIN; m_k counts RUN cycles,
    // capture in RUN cycle k iff floor((k+1)*NUM/DEN) exceeds floor(k*NUM/DEN).
    int         m_state   = 0;
    int         m_settled = 0;
    int         m_k       = 0;
    bit         m_ovf     = 1'b0;
    bit         started   = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] m_log[$];

    task automatic model_step();
        int sz;
        bit p, cap;
        started = 1'b1;
        if (RST) begin
            m_state = 0; m_settled = 0; m_k = 0; m_ovf = 1'b0;
            m_q.delete(); m_log.delete();
            return;
        end
        sz  = m_q.size();
        p   = (sz > 0) && OUT_READY;
        cap = (m_state == 2) && (((m_k + 1) * NUM) / DEN > (m_k * NUM) / DEN);
        if (p) void'(m_q.pop_front());
        if (cap) begin
            m_log.push_back(FILT_OUT);
            if (sz < DEPTH || p) m_q.push_back(FILT_OUT);
            else                 m_ovf = 1'b1;
        end
        case (m_state)
            0: if (EN) begin m_state = 1; m_settled = 0; end
            1: begin
                m_settled++;
                if (!EN)                     m_state = 0;
                else if (m_settled == SETTLE) begin m_state = 2; m_k = 0; end
            end
            2: begin m_k++; if (!EN) m_state = 3; end
            3: if (sz == 0) m_state = 0;
            default: m_state = 0;
        endcase
        if (m_state == 0) m_ovf = 1'b0;
    endtask

    always @(posedge CLK) model_step();

    always @(negedge CLK) begin
        if (started) begin
            chk("STATE",     int'(STATE),     m_state);
            chk("FILT_CLR",  int'(FILT_CLR),  int'(m_state == 0));
            chk("FILT_EN",   int'(FILT_EN),   int'(m_state == 1 || m_state == 2));
            chk("OUT_VALID", int'(OUT_VALID), int'(m_q.size() > 0));
            chk("OUT_DATA",  int'(OUT_DATA),  (m_q.size() > 0) ? int'(m_q[0]) : 0);
            chk("OVF",       int'(OVF),       int'(m_ovf));
            chk("CLR_EN_EXCL", int'(FILT_CLR && FILT_EN), 0);
        end
    end

    task automatic cyc();
        @(negedge CLK);
        FILT_OUT = 8'($urandom);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        EN  = 1'b0;
        repeat (2) cyc();
        chk("rst_state", int'(STATE), 0);
        chk("rst_clr",   int'(FILT_CLR), 1);
        chk("rst_valid", int'(OUT_VALID), 0);
        chk("rst_data",  int'(OUT_DATA), 0);
        chk("rst_ovf",   int'(OVF), 0);
        RST = 1'b0;
    endtask

    // Returns at the negedge of RUN cycle 0 (or when the bound expires).
    task automatic start_run(input bit rdy, output int settle_n);
        EN = 1'b1;
        OUT_READY = rdy;
        cyc();
        settle_n = 0;
        while (STATE == 2'd1 && settle_n < 100) begin
            settle_n++;
            cyc();
        end
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sn, r, pops, p;

        // Power-up, settle length, first-sample latency.
        do_reset();
        start_run(1'b1, sn);
        chk("settle_len", sn, 32);
        chk("run_entry", int'(STATE), 2);
        r = 0;
        while (!OUT_VALID && r < 20) begin r++; cyc(); end
        chk("first_valid_lat", r, 2);

        // Steady RUN, consumer always ready.
        pops = 0;
        repeat (160) begin
            if (OUT_VALID && OUT_READY) pops++;
            cyc();
        end
        chk("pops_160", pops, 110);
        chk("ovf_steady", int'(OVF), 0);

        // Consumer stalled: fifth capture overflows.
        do_reset();
        start_run(1'b0, sn);
        r = 0;
        while (!OVF && r < 30) begin r++; cyc(); end
        chk("ovf_set", int'(OVF), 1);
        chk("ovf_cycle", r, 8);
        chk("ovf_valid", int'(OUT_VALID), 1);
        chk("ovf_data", int'(OUT_DATA), int'(m_log[0]));
        chk("ovf_queued", m_q.size(), 4);
        chk("ovf_captures", m_log.size(), 5);

        // Full FIFO, single-cycle ready on a capture cycle.
        do_reset();
        start_run(1'b0, sn);
        repeat (7) cyc();
        chk("full_pre_occ", m_q.size(), 4);
        OUT_READY = 1'b1;
        cyc();
        OUT_READY = 1'b0;
        chk("both_ovf", int'(OVF), 0);
        chk("both_data", int'(OUT_DATA), int'(m_log[1]));
        chk("both_occ", m_q.size(), 4);

        // Leave RUN with three queued samples, then drain.
        do_reset();
        start_run(1'b0, sn);
        repeat (5) cyc();
        chk("pre_drain_occ", m_q.size(), 3);
        EN = 1'b0;
        OUT_READY = 1'b1;
        cyc();
        chk("drain_state", int'(STATE), 3);
        chk("drain_fen", int'(FILT_EN), 0);
        EN = 1'b1;
        pops = 0;
        r = 0;
        while (STATE == 2'd3 && r < 20) begin
            if (OUT_VALID && OUT_READY) pops++;
            r++;
            cyc();
        end
        chk("drain_pops", pops, 3);
        chk("drain_len", r, 4);
        chk("idle_state", int'(STATE), 0);
        chk("idle_clr", int'(FILT_CLR), 1);

        // Reset mid-RUN with two queued samples.
        do_reset();
        start_run(1'b0, sn);
        repeat (3) cyc();
        chk("pre_rst_occ", m_q.size(), 2);
        RST = 1'b1;
        cyc();
        chk("midrst_state", int'(STATE), 0);
        chk("midrst_valid", int'(OUT_VALID), 0);
        chk("midrst_ovf", int'(OVF), 0);
        chk("midrst_data", int'(OUT_DATA), 0);
        RST = 1'b0;
        start_run(1'b1, sn);
        r = 0;
        while (!OUT_VALID && r < 20) begin r++; cyc(); end
        chk("restart_lat", r, 2);
        chk("restart_data", int'(OUT_DATA), int'(m_log[0]));

        // Randomized traffic with varying consumer throughput.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            p = $urandom_range(20, 100);
            repeat (200) begin
                RST       = ($urandom_range(0, 199) == 0);
                EN        = ($urandom_range(0, 99) < 97);
                OUT_READY = ($urandom_range(0, 99) < p);
                cyc();
            end
        end
        RST = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decim_ctrl.md
DECIM_CTRL -- requirements
Module: decim_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM, 11, decimation numerator (output samples per DEN input bits).
- DEN, 16, decimation denominator; NUM < DEN.
- SETTLE, 32, filter warm-up length in input-bit cycles.
- DEPTH, 4, output FIFO entries (power of two).

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, sole clock; all logic on rising edge.
- RST, in, 1, synchronous, active-high reset.
- EN, in, 1, run request.
- FILT_OUT, in, 8, current Filter output word.
- FILT_CLR, out, 1, clears Filter accumulators.
- FILT_EN, out, 1, Filter consumes one input bit this cycle.
- OUT_DATA, out, 8, decimated sample.
- OUT_VALID, out, 1, OUT_DATA valid.
- OUT_READY, in, 1, consumer accepts sample.
- OVF, out, 1, sticky overflow flag (sample dropped).
- STATE, out, 2, current FSM state code.

Function
REQ-003 FSM states and codes: IDLE=0, SETTLE=1, RUN=2, DRAIN=3.
REQ-004 IDLE:
- FILT_CLR=1, FILT_EN=0.
- EN=1 moves to SETTLE on the next cycle.
- Entering IDLE from any state clears OVF.
REQ-005 SETTLE:
- FILT_CLR=0, FILT_EN=1, no captures.
- Lasts exactly SETTLE cycles, then moves to RUN.
- EN=0 during SETTLE returns to IDLE on the next cycle.
REQ-006 RUN:
- FILT_EN=1.
- 5-bit phase accumulator, 0 on RUN entry; each cycle sum = phase+NUM.
- If sum >= DEN: phase <= sum-DEN and FILT_OUT is captured into the FIFO that cycle; else phase <= sum.
REQ-007 With NUM=11, DEN=16, exactly 11 captures occur per 16 consecutive RUN cycles; the first capture is in RUN cycle 1 (0-indexed).
REQ-008 Capture-to-output latency: a capture into an empty FIFO raises OUT_VALID on the next cycle with OUT_DATA equal to the captured word.
REQ-009 Handshake:
- A pop occurs when OUT_VALID && OUT_READY.
- OUT_DATA and OUT_VALID hold stable while OUT_VALID && !OUT_READY.
- Samples leave in capture order.
REQ-010 Full FIFO boundary:
- Capture while full with no pop in the same cycle drops the sample and sets OVF=1.
- Capture and pop in the same cycle while full both succeed; OVF is unchanged.
REQ-011 EN=0 in RUN moves to DRAIN on the next cycle; the capture decision of that final RUN cycle still applies.
REQ-012 DRAIN:
- FILT_EN=0, no captures, EN ignored.
- Moves to IDLE on the cycle after the FIFO becomes empty.
- Moves to IDLE immediately if the FIFO is already empty on entry.
REQ-013 FILT_CLR and FILT_EN are never both 1.

Reset
REQ-014 RST=1 at a clock edge forces, on that edge, regardless of state (including mid-RUN or mid-DRAIN):
- STATE=IDLE, FILT_CLR=1, FILT_EN=0.
- OUT_VALID=0, OUT_DATA=0, OVF=0.
- Phase and settle counters 0; FIFO empty.
REQ-015 Samples in flight at reset are discarded; none are output after RST deasserts.

Structure
REQ-016 Shared package/include decim_pkg holds:
- state codes;
- default NUM, DEN, SETTLE, DEPTH values;
- FIFO width constant 8.
REQ-017 Sub-module decim_fifo: synchronous, DEPTH x 8, with push/pop/full/empty and simultaneous push+pop support; the FSM and phase accumulator stay in decim_ctrl.

Verification
REQ-018 Reset then EN=1, OUT_READY=1 -> STATE 0->1, exactly 32 cycles of SETTLE, then RUN; first OUT_VALID 2 cycles after RUN entry.
REQ-019 Steady RUN over 160 cycles, OUT_READY=1 -> exactly 110 samples popped, OVF=0, order matches FILT_OUT at capture cycles.
REQ-020 OUT_READY=0 throughout RUN -> FIFO holds 4 samples, fifth capture sets OVF=1, OUT_DATA remains first captured word.
REQ-021 FIFO full, OUT_READY=1 on a capture cycle -> push and pop both occur, OVF stays 0, occupancy stays 4.
REQ-022 EN=0 in RUN with 3 queued samples, OUT_READY=1 -> DRAIN, FILT_EN=0, 3 pops, then IDLE with FILT_CLR=1.
REQ-023 RST=1 mid-RUN with 2 queued samples -> next cycle STATE=0, OUT_VALID=0, OVF=0; no stale samples after restart.
